i2c_target_regs: RTL

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_line_filter.sv | 43 ++++
 rtl/i2c_target_regs.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus-level constants for the I2C register target
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchronises one bus line, rejects short glitches and flags level edges
module i2c_line_filter #(
    parameter int FILTER_LEN = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic [3:0] cnt_q;
    logic       level_q;
    logic       prev_q;

    // two-flop synchroniser, then a new level is accepted after FILTER_LEN matching samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line_i};
            prev_q <= level_q;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~prev_q;
    assign fall_o  = ~level_q & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target exposing a pointer-addressed bank of 8-bit registers
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] BASE_ADDR = 7'h50,
    parameter int NUM_ADDR_PINS = 2,
    parameter int DEPTH         = 16,
    parameter int FILTER_LEN    = 2,
    localparam int PW = (NUM_ADDR_PINS > 0) ? NUM_ADDR_PINS : 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic [PW-1:0] addr_pins,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          wr_valid,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    localparam logic [I2C_ADDR_W-1:0] PIN_MASK = I2C_ADDR_W'((1 << NUM_ADDR_PINS) - 1);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (scl_i),
        .level_o(scl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (sda_i),
        .level_o(sda),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    i2c_state_e                  state_q;
    logic [3:0]                  bit_cnt_q;
    logic [7:0]                  rx_q;
    logic [7:0]                  tx_q;
    logic [AW-1:0]               ptr_q;
    logic                        rw_q;
    logic                        sda_oe_q;
    logic                        busy_q;
    logic                        wr_valid_q;
    logic [AW-1:0]               wr_addr_q;
    logic [7:0]                  wr_data_q;
    logic [7:0]                  regs_q [DEPTH];

    logic                        start;
    logic                        stop;
    logic [I2C_ADDR_W-1:0]       tgt_addr;
    logic                        addr_hit;
    logic                        ptr_ok;
    logic                        byte_done;
    logic                        i2c_we;
    logic [AW-1:0]               ptr_nx;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign start     = sda_fall & scl;
    assign stop      = sda_rise & scl;
    assign tgt_addr  = (BASE_ADDR & ~PIN_MASK) | (I2C_ADDR_W'(addr_pins) & PIN_MASK);
    assign addr_hit  = rx_q[7:1] == tgt_addr;
    assign ptr_ok    = 32'(rx_q) < DEPTH;
    assign byte_done = bit_cnt_q == 4'd8;
    assign ptr_nx    = ptr_inc(ptr_q);
    assign i2c_we    = (state_q == ST_WDATA) && scl_fall && byte_done && !start && !stop;

    // bus protocol engine: START/STOP take priority, bits are shifted on scl edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            ptr_q      <= '0;
            rw_q       <= RW_WRITE;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_valid_q <= i2c_we;
            if (i2c_we) begin
                wr_addr_q <= ptr_q;
                wr_data_q <= rx_q;
            end
            if (start) begin
                state_q   <= ST_ADDR;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b1;
            end else if (stop) begin
                state_q  <= ST_IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (state_q != ST_IDLE) begin
                if (scl_rise) begin
                    rx_q      <= {rx_q[6:0], sda};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
                if (scl_fall) begin
                    case (state_q)
                        ST_ADDR: if (byte_done) begin
                            state_q  <= addr_hit ? ST_ADDR_ACK : ST_IDLE;
                            sda_oe_q <= addr_hit;
                            rw_q     <= rx_q[0];
                        end
                        ST_ADDR_ACK: begin
                            bit_cnt_q <= '0;
                            if (rw_q == RW_READ) begin
                                state_q  <= ST_RDATA;
                                tx_q     <= regs_q[ptr_q];
                                sda_oe_q <= ~regs_q[ptr_q][7];
                            end else begin
                                state_q  <= ST_PTR;
                                sda_oe_q <= 1'b0;
                            end
                        end
                        ST_PTR: if (byte_done) begin
                            state_q  <= ptr_ok ? ST_PTR_ACK : ST_IDLE;
                            sda_oe_q <= ptr_ok;
                            if (ptr_ok) ptr_q <= rx_q[AW-1:0];
                        end
                        ST_PTR_ACK, ST_WDATA_ACK: begin
                            state_q   <= ST_WDATA;
                            bit_cnt_q <= '0;
                            sda_oe_q  <= 1'b0;
                        end
                        ST_WDATA: if (byte_done) begin
                            state_q  <= ST_WDATA_ACK;
                            sda_oe_q <= 1'b1;
                            ptr_q    <= ptr_nx;
                        end
                        ST_RDATA: if (byte_done) begin
                            state_q  <= ST_RDATA_ACK;
                            sda_oe_q <= 1'b0;
                        end else begin
                            tx_q     <= {tx_q[6:0], 1'b0};
                            sda_oe_q <= ~tx_q[6];
                        end
                        ST_RDATA_ACK: if (rx_q[0] == ACK) begin
                            state_q   <= ST_RDATA;
                            bit_cnt_q <= '0;
                            ptr_q     <= ptr_nx;
                            tx_q      <= regs_q[ptr_nx];
                            sda_oe_q  <= ~regs_q[ptr_nx][7];
                        end else begin
                            state_q  <= ST_IDLE;
                            sda_oe_q <= 1'b0;
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    // register bank: a same-cycle I2C write to the host's index lands last and wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            if (host_we) regs_q[host_addr] <= host_wdata;
            if (i2c_we) regs_q[ptr_q] <= rx_q;
        end
    end

    assign host_rdata = regs_q[host_addr];
    assign sda_oe     = sda_oe_q;
    assign busy       = busy_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;

endmodule
